turn_scheduler: RTL and testbench

Turn sequencer for the board game datapath. It rotates play among up to four enabled players and captures each player's tile selection from the keypad. It issues one move request per selection to the board/tile datapath over a req/ack handshake, then decides the outcome: the same player continues, the turn passes, or the game ends. It sits between the keypad decoder and the board datapath and replaces ad-hoc turn bookkeeping in the top level.

---
 rtl/turn_pkg.sv | 24 ++
 rtl/rr_next.sv | 29 ++
 rtl/turn_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_turn_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/turn_pkg.sv
// Shared definitions for the turn sequencer: state encoding, player index
// width and the keypad "no key" code.
package turn_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_KEY = 3'd1;
    localparam logic [2:0] ST_REQUEST  = 3'd2;
    localparam logic [2:0] ST_RESOLVE  = 3'd3;
    localparam logic [2:0] ST_ADVANCE  = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        WAIT_KEY = ST_WAIT_KEY,
        REQUEST  = ST_REQUEST,
        RESOLVE  = ST_RESOLVE,
        ADVANCE  = ST_ADVANCE,
        DONE     = ST_DONE
    } state_t;

    localparam int         PLAYER_W = 2;
    localparam logic [3:0] KEY_NONE = 4'd0;

endpackage

// File: rtl/rr_next.sv
// Combinational round-robin search: returns the first enabled index after
// i_cur, wrapping 3 -> 0. If only i_cur is enabled it returns i_cur; with an
// empty mask it also returns i_cur.
module rr_next
    import turn_pkg::*;
(
    input  logic [3:0]          i_mask,
    input  logic [PLAYER_W-1:0] i_cur,
    output logic [PLAYER_W-1:0] o_next
);

    logic [PLAYER_W-1:0] w_idx;
    logic                w_found;

    // Walk offsets 1..4 from the current index; offset 4 lands back on i_cur.
    always_comb begin
        o_next  = i_cur;
        w_found = 1'b0;
        w_idx   = i_cur;
        for (int off = 1; off <= 4; off++) begin
            w_idx = i_cur + PLAYER_W'(off);
            if (!w_found && i_mask[w_idx]) begin
                o_next  = w_idx;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/turn_scheduler.sv
// Turn sequencer: rotates play among enabled players, captures keypad tile
// selections, issues one move request per selection and resolves the result.
// Handshake: mv_req rises one cycle after a valid key event and stays high,
// with mv_tile/mv_player stable, up to and including the cycle mv_ack=1;
// it drops on the following edge. mv_ack outside REQUEST is ignored.
module turn_scheduler
    import turn_pkg::*;
#(
    parameter int NUM_PLAYERS    = 4,
    parameter int MAX_TILE       = 12,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NUM_PLAYERS-1:0] player_en,
    input  logic [3:0]             key,
    output logic                   mv_req,
    output logic [3:0]             mv_tile,
    output logic [1:0]             mv_player,
    input  logic                   mv_ack,
    input  logic                   mv_match,
    input  logic                   mv_win,
    output logic [1:0]             cur_player,
    output logic                   turn_active,
    output logic                   timeout,
    output logic                   game_over,
    output logic [1:0]             winner,
    output logic [2:0]             state
);

    localparam int               CLOG_T     = $clog2(TIMEOUT_CYCLES);
    localparam int               TW         = (CLOG_T > 26) ? CLOG_T : 26;
    localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       TILE_MAX   = 4'(MAX_TILE);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_key_prev;
    logic [TW-1:0]       r_timer;
    logic [3:0]          r_en_mask;
    logic [PLAYER_W-1:0] r_cur_player;
    logic [PLAYER_W-1:0] r_winner;
    logic [3:0]          r_mv_tile;
    logic [PLAYER_W-1:0] r_mv_player;
    logic                r_match;
    logic                r_win;
    logic                r_timeout;

    logic [3:0]          w_start_mask;
    logic [PLAYER_W-1:0] w_first_player;
    logic [PLAYER_W-1:0] w_adv_player;
    logic                w_key_event;
    logic                w_key_valid;
    logic                w_timer_last;
    logic                w_go_start;
    logic                w_take_key;
    logic                w_expire;
    logic                w_capture;
    logic                w_set_winner;
    logic                w_restart;
    logic                w_advance;

    // Widen the player mask to four slots; slots beyond NUM_PLAYERS stay 0.
    always_comb begin
        w_start_mask                  = '0;
        w_start_mask[NUM_PLAYERS-1:0] = player_en;
    end

    // Searching after index 3 wraps to 0 first, yielding the lowest enabled.
    rr_next u_rr_first (
        .i_mask (w_start_mask),
        .i_cur  (2'd3),
        .o_next (w_first_player)
    );

    rr_next u_rr_adv (
        .i_mask (r_en_mask),
        .i_cur  (r_cur_player),
        .o_next (w_adv_player)
    );

    assign w_key_event  = (key != KEY_NONE) && (r_key_prev == KEY_NONE);
    assign w_key_valid  = w_key_event && (key <= TILE_MAX);
    assign w_timer_last = (r_timer == TIMER_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and datapath strobes; a valid key beats expiry.
    always_comb begin
        w_state_nxt  = r_state;
        w_go_start   = 1'b0;
        w_take_key   = 1'b0;
        w_expire     = 1'b0;
        w_capture    = 1'b0;
        w_set_winner = 1'b0;
        w_restart    = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start && (w_start_mask != 4'd0)) begin
                    w_go_start  = 1'b1;
                    w_state_nxt = WAIT_KEY;
                end
            end
            WAIT_KEY: begin
                if (w_key_valid) begin
                    w_take_key  = 1'b1;
                    w_state_nxt = REQUEST;
                end else if (w_timer_last) begin
                    w_expire    = 1'b1;
                    w_state_nxt = ADVANCE;
                end
            end
            REQUEST: begin
                if (mv_ack) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RESOLVE;
                end
            end
            RESOLVE: begin
                if (r_win) begin
                    w_set_winner = 1'b1;
                    w_state_nxt  = DONE;
                end else if (r_match) begin
                    w_restart   = 1'b1;
                    w_state_nxt = WAIT_KEY;
                end else begin
                    w_state_nxt = ADVANCE;
                end
            end
            ADVANCE: begin
                w_advance   = 1'b1;
                w_state_nxt = WAIT_KEY;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers driven by the strobes above.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_prev   <= KEY_NONE;
            r_timer      <= '0;
            r_en_mask    <= '0;
            r_cur_player <= '0;
            r_winner     <= '0;
            r_mv_tile    <= '0;
            r_mv_player  <= '0;
            r_match      <= 1'b0;
            r_win        <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_key_prev <= key;
            r_timeout  <= w_expire;
            if (r_state == WAIT_KEY && !w_timer_last) begin
                r_timer <= r_timer + TW'(1);
            end
            if (w_go_start) begin
                r_en_mask    <= w_start_mask;
                r_cur_player <= w_first_player;
                r_timer      <= '0;
            end
            if (w_take_key) begin
                r_mv_tile   <= key;
                r_mv_player <= r_cur_player;
            end
            if (w_capture) begin
                r_match <= mv_match;
                r_win   <= mv_win;
            end
            if (w_set_winner) begin
                r_winner <= r_cur_player;
            end
            if (w_restart) begin
                r_timer <= '0;
            end
            if (w_advance) begin
                r_cur_player <= w_adv_player;
                r_timer      <= '0;
            end
        end
    end

    assign mv_req      = (r_state == REQUEST);
    assign mv_tile     = r_mv_tile;
    assign mv_player   = r_mv_player;
    assign cur_player  = r_cur_player;
    assign turn_active = (r_state == WAIT_KEY);
    assign timeout     = r_timeout;
    assign game_over   = (r_state == DONE);
    assign winner      = r_winner;
    assign state       = r_state;

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler with TIMEOUT_CYCLES=8. Move requests are
// predicted into a queue and checked by a monitor on each mv_req rise.
module tb_turn_scheduler;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] player_en;
    logic [3:0] key;
    logic       mv_req;
    logic [3:0] mv_tile;
    logic [1:0] mv_player;
    logic       mv_ack;
    logic       mv_match;
    logic       mv_win;
    logic [1:0] cur_player;
    logic       turn_active;
    logic       timeout;
    logic       game_over;
    logic [1:0] winner;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;
    int tout_cnt = 0;
    int exp_tout = 0;
    logic prev_req = 1'b0;
    logic [5:0] exp_q[$];

    turn_scheduler #(
        .NUM_PLAYERS    (4),
        .MAX_TILE       (12),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .player_en   (player_en),
        .key         (key),
        .mv_req      (mv_req),
        .mv_tile     (mv_tile),
        .mv_player   (mv_player),
        .mv_ack      (mv_ack),
        .mv_match    (mv_match),
        .mv_win      (mv_win),
        .cur_player  (cur_player),
        .turn_active (turn_active),
        .timeout     (timeout),
        .game_over   (game_over),
        .winner      (winner),
        .state       (state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, actual=running required=finished");
        bad = bad + 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare each new request against the predicted queue; count timeouts.
    always @(negedge clk) begin
        if (mv_req && !prev_req) begin
            if (exp_q.size() == 0) begin
                total = total + 1;
                bad = bad + 1;
                $display("FAIL unexpected_req: actual=%0h required=none", {mv_player, mv_tile});
            end else begin
                check("req_fields", {26'd0, mv_player, mv_tile}, {26'd0, exp_q.pop_front()});
            end
        end
        prev_req = mv_req;
        if (timeout) tout_cnt = tout_cnt + 1;
    end

    // One move: optional idle cycles, key pulse, optional ack delay, ack.
    task automatic move(input logic [3:0] k, input logic [1:0] p, input logic m,
                        input logic w, input int pre, input int hold);
        repeat (pre) tick();
        exp_q.push_back({p, k});
        key = k;
        tick();
        key = 4'd0;
        check("req_rise", mv_req, 1);
        check("req_no_timeout", timeout, 0);
        repeat (hold) begin
            tick();
            check("req_hold", mv_req, 1);
        end
        mv_ack = 1'b1;
        mv_match = m;
        mv_win = w;
        tick();
        mv_ack = 1'b0;
        mv_match = 1'b0;
        mv_win = 1'b0;
        check("ack_to_resolve", state, 3);
        check("req_drop", mv_req, 0);
    endtask

    task automatic start_game(input logic [3:0] en);
        player_en = en;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; player_en = 4'd0; key = 4'd0;
        mv_ack = 1'b0; mv_match = 1'b0; mv_win = 1'b0;
        tick(); tick();
        check("rst_state", state, 0);
        check("rst_req", mv_req, 0);
        check("rst_cur", cur_player, 0);
        check("rst_tile", {mv_player, mv_tile}, 0);
        check("rst_flags", {game_over, turn_active, timeout, winner}, 0);
        rst = 1'b0;
        tick();

        // Game with players 0,1,3; miss passes the turn.
        start_game(4'b1011);
        check("start_state", state, 1);
        check("start_cur", cur_player, 0);
        check("start_active", turn_active, 1);
        move(4'd3, 2'd0, 1'b0, 1'b0, 0, 0);
        tick();
        check("miss_advance", state, 4);
        tick();
        check("miss_wait", state, 1);
        check("miss_cur1", cur_player, 1);

        // Match after 4 idle cycles: same player, timer restarted.
        move(4'd5, 2'd1, 1'b1, 1'b0, 4, 0);
        tick();
        check("match_state", state, 1);
        check("match_cur", cur_player, 1);
        check("match_active", turn_active, 1);

        // Timeout after 8 cycles in WAIT_KEY.
        repeat (7) tick();
        check("pre_tout_state", state, 1);
        check("pre_tout_pulse", timeout, 0);
        tick();
        exp_tout = exp_tout + 1;
        check("tout_pulse", timeout, 1);
        check("tout_state", state, 4);
        tick();
        check("tout_one_cycle", timeout, 0);
        check("tout_cur3", cur_player, 3);

        // Player 3 misses with a held-off ack; turn wraps to 0.
        move(4'd7, 2'd3, 1'b0, 1'b0, 0, 2);
        tick(); tick();
        check("wrap_cur0", cur_player, 0);

        // Key in the expiry cycle wins over timeout.
        move(4'd9, 2'd0, 1'b0, 1'b0, 7, 0);
        tick(); tick();
        check("late_key_cur1", cur_player, 1);

        // Held key: one request only; match keeps player 1.
        exp_q.push_back({2'd1, 4'd2});
        key = 4'd2;
        tick();
        check("held_req", mv_req, 1);
        mv_ack = 1'b1; mv_match = 1'b1;
        tick();
        mv_ack = 1'b0; mv_match = 1'b0;
        repeat (8) tick();
        check("held_no_second", state, 1);
        key = 4'd0;
        tick();
        exp_tout = exp_tout + 1;
        check("held_tout", timeout, 1);
        tick();
        check("held_cur3", cur_player, 3);

        // Out-of-range key is ignored.
        key = 4'd14;
        tick();
        check("bad_key_state", state, 1);
        key = 4'd0;
        tick();
        check("bad_key_req", mv_req, 0);

        // Win with match also set: win takes priority.
        move(4'd11, 2'd3, 1'b1, 1'b1, 0, 0);
        tick();
        check("win_state", state, 5);
        check("win_over", game_over, 1);
        check("win_winner", winner, 3);
        check("win_inactive", turn_active, 0);

        // Restart with a new mask: lowest enabled is 1, next is 2.
        start_game(4'b0110);
        check("restart_cur", cur_player, 1);
        move(4'd4, 2'd1, 1'b0, 1'b0, 0, 0);
        tick(); tick();
        check("new_mask_cur2", cur_player, 2);

        // Reset while the request is outstanding.
        exp_q.push_back({2'd2, 4'd6});
        key = 4'd6;
        tick();
        key = 4'd0;
        check("abandon_req", mv_req, 1);
        rst = 1'b1;
        tick();
        check("rst_mid_req", mv_req, 0);
        check("rst_mid_cur", cur_player, 0);
        check("rst_mid_state", state, 0);
        rst = 1'b0;
        tick();

        // Start with empty mask is ignored.
        start_game(4'b0000);
        check("empty_start", state, 0);
        tick();
        check("empty_start_hold", state, 0);

        // Single enabled player keeps the turn after a miss; start mid-game ignored.
        start_game(4'b0100);
        check("single_cur", cur_player, 2);
        move(4'd1, 2'd2, 1'b0, 1'b0, 0, 0);
        tick(); tick();
        check("single_stays", cur_player, 2);
        start_game(4'b1011);
        check("midgame_start_cur", cur_player, 2);
        check("midgame_start_state", state, 1);

        tick();
        check("queue_empty", exp_q.size(), 0);
        check("timeout_count", tout_cnt, exp_tout);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
